// File: rtl/dom_shared_gf4_mac_pipe.sv
// Domain-oriented masked GF(2^2) multiply / square-scale-multiply-accumulate
// with a one-deep registered output stage and valid/ready handshaking.
module dom_shared_gf4_mac_pipe #(
  parameter int SHARES = 2,
  parameter int LANES  = 1
) (
  input  logic                                ClkxCI,
  input  logic                                RstxBI,
  input  logic [2*SHARES*LANES-1:0]           _XxDI,
  input  logic [2*SHARES*LANES-1:0]           _YxDI,
  input  logic [SHARES*(SHARES-1)*LANES-1:0]  _ZxDI,
  input  logic                                ModexSI,
  input  logic                                ValidxSI,
  output logic                                ReadyxSO,
  output logic [2*SHARES*LANES-1:0]           _QxDO,
  output logic                                ValidxSO,
  input  logic                                ReadyxSI
);

  localparam int P = SHARES * (SHARES - 1) / 2;
  localparam int TERM_W = 2 * SHARES * SHARES * LANES;

  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf4_sqsc(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // Lexicographic index of the unordered share pair {i,j}, i != j.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic              valid_q, valid_d;
  logic [TERM_W-1:0] term_q, term_d;
  logic              accept;
  logic [2*SHARES*LANES-1:0] q_comb;

  assign ReadyxSO = !valid_q | ReadyxSI;
  assign accept   = ValidxSI & ReadyxSO;
  assign ValidxSO = valid_q;

  always_comb begin
    valid_d = valid_q;
    if (accept) begin
      valid_d = 1'b1;
    end else if (ReadyxSI) begin
      valid_d = 1'b0;
    end
  end

  // Term matrix per lane: diagonal holds the inner-domain term, off-diagonal
  // entry (i,j) holds mul(X_i,Y_j) refreshed with the pair's mask.
  always_comb begin
    term_d = term_q;
    if (accept) begin
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < SHARES; i++) begin
          for (int j = 0; j < SHARES; j++) begin
            if (i == j) begin
              term_d[((l*SHARES+i)*SHARES+j)*2 +: 2] =
                gf4_mul(_XxDI[(l*SHARES+i)*2 +: 2], _YxDI[(l*SHARES+i)*2 +: 2]) ^
                (ModexSI ? gf4_sqsc(_XxDI[(l*SHARES+i)*2 +: 2] ^ _YxDI[(l*SHARES+i)*2 +: 2])
                         : 2'b00);
            end else begin
              term_d[((l*SHARES+i)*SHARES+j)*2 +: 2] =
                gf4_mul(_XxDI[(l*SHARES+i)*2 +: 2], _YxDI[(l*SHARES+j)*2 +: 2]) ^
                _ZxDI[(l*P+pair_idx(i, j))*2 +: 2];
            end
          end
        end
      end
    end
  end

  // Output shares are formed only from registered terms.
  always_comb begin
    q_comb = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          q_comb[(l*SHARES+i)*2 +: 2] = q_comb[(l*SHARES+i)*2 +: 2] ^
                                        term_q[((l*SHARES+i)*SHARES+j)*2 +: 2];
        end
      end
    end
  end

  assign _QxDO = q_comb;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      valid_q <= 1'b0;
      term_q  <= '0;
    end else begin
      valid_q <= valid_d;
      term_q  <= term_d;
    end
  end

endmodule

// File: tb/tb_dom_shared_gf4_mac_pipe.sv
// Directed and regression bench for dom_shared_gf4_mac_pipe: a 2-share single
// lane instance and a 3-share four-lane instance checked against an unshared model.
module tb_dom_shared_gf4_mac_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] xa, ya, qa;
  logic [1:0] za;
  logic mode_a, vin_a, rin_a, rout_a, vout_a;

  logic [23:0] xb, yb, zb, qb;
  logic mode_b, vin_b, rin_b, rout_b, vout_b;

  int total = 0;
  int bad = 0;

  localparam logic [3:0] DX [3] = '{4'b0010, 4'b0010, 4'b1001};
  localparam logic [3:0] DY [3] = '{4'b0001, 4'b0001, 4'b0110};
  localparam logic       DM [3] = '{1'b0, 1'b1, 1'b1};
  localparam logic [1:0] DE [3] = '{2'b11, 2'b01, 2'b11};

  dom_shared_gf4_mac_pipe #(.SHARES(2), .LANES(1)) dut_a (
    .ClkxCI(clk), .RstxBI(rst_n),
    ._XxDI(xa), ._YxDI(ya), ._ZxDI(za),
    .ModexSI(mode_a), .ValidxSI(vin_a), .ReadyxSO(rout_a),
    ._QxDO(qa), .ValidxSO(vout_a), .ReadyxSI(rin_a)
  );

  dom_shared_gf4_mac_pipe #(.SHARES(3), .LANES(4)) dut_b (
    .ClkxCI(clk), .RstxBI(rst_n),
    ._XxDI(xb), ._YxDI(yb), ._ZxDI(zb),
    .ModexSI(mode_b), .ValidxSI(vin_b), .ReadyxSO(rout_b),
    ._QxDO(qb), .ValidxSO(vout_b), .ReadyxSI(rin_b)
  );

  function automatic logic [1:0] m_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  function automatic logic [1:0] m_func(input logic [1:0] x, input logic [1:0] y, input logic m);
    logic [1:0] s;
    s = x ^ y;
    return m ? ({s[1], s[1] ^ s[0]} ^ m_mul(x, y)) : m_mul(x, y);
  endfunction

  function automatic logic [1:0] comb_a(input logic [3:0] v);
    return v[3:2] ^ v[1:0];
  endfunction

  function automatic logic [7:0] lanes_b(input logic [23:0] v);
    logic [7:0] r;
    r = '0;
    for (int l = 0; l < 4; l++)
      for (int s = 0; s < 3; s++)
        r[l*2 +: 2] = r[l*2 +: 2] ^ v[(l*3+s)*2 +: 2];
    return r;
  endfunction

  function automatic logic [7:0] exp_b(input logic [23:0] x, input logic [23:0] y, input logic m);
    logic [7:0] xl, yl, r;
    xl = lanes_b(x);
    yl = lanes_b(y);
    for (int l = 0; l < 4; l++) r[l*2 +: 2] = m_func(xl[l*2 +: 2], yl[l*2 +: 2], m);
    return r;
  endfunction

  task automatic test_reset;
    xa = '0; ya = '0; za = '0; mode_a = 0; vin_a = 0; rin_a = 0;
    xb = '0; yb = '0; zb = '0; mode_b = 0; vin_b = 0; rin_b = 0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (vout_a !== 1'b0 || qa !== 4'b0 || rout_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_a: got v=%b q=%b r=%b want v=0 q=0000 r=1", vout_a, qa, rout_a);
    end
    total++;
    if (vout_b !== 1'b0 || qb !== 24'b0 || rout_b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_b: got v=%b q=%h r=%b want v=0 q=0 r=1", vout_b, qb, rout_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      xa = DX[i]; ya = DY[i]; za = 2'($urandom()); mode_a = DM[i];
      vin_a = 1; rin_a = 1;
      @(posedge clk);
      #1;
      vin_a = 0;
      total++;
      if (vout_a !== 1'b1 || comb_a(qa) !== DE[i]) begin
        bad++;
        $display("[TB] FAIL directed%0d: got v=%b q=%b want v=1 q=%b", i, vout_a, comb_a(qa), DE[i]);
      end
    end
  endtask

  task automatic test_exhaustive;
    logic [1:0] e;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        @(negedge clk);
        xa = 4'(v); ya = 4'(v >> 4); za = 2'($urandom()); mode_a = m[0];
        vin_a = 1; rin_a = 1;
        e = m_func(xa[1:0] ^ xa[3:2], ya[1:0] ^ ya[3:2], mode_a);
        @(posedge clk);
        #1;
        total++;
        if (vout_a !== 1'b1 || comb_a(qa) !== e) begin
          bad++;
          $display("[TB] FAIL exhaustive m=%0d v=%0d: got v=%b q=%b want v=1 q=%b",
                   m, v, vout_a, comb_a(qa), e);
        end
      end
    end
    vin_a = 0;
  endtask

  task automatic test_backpressure;
    logic [3:0] held;
    logic [1:0] e;
    @(negedge clk);
    xa = 4'b0110; ya = 4'b1011; za = 2'($urandom()); mode_a = 0; vin_a = 1; rin_a = 1;
    e = m_func(2'b10 ^ 2'b01, 2'b11 ^ 2'b10, 1'b0);
    @(posedge clk);
    #1;
    held = qa;
    total++;
    if (comb_a(qa) !== e) begin
      bad++;
      $display("[TB] FAIL bp_first: got %b want %b", comb_a(qa), e);
    end
    @(negedge clk);
    xa = 4'b1100; ya = 4'b0101; za = 2'($urandom()); mode_a = 1; rin_a = 0;
    #1;
    total++;
    if (rout_a !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_ready_low: got %b want 0", rout_a);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (qa !== held || vout_a !== 1'b1 || rout_a !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold%0d: got q=%b v=%b r=%b want q=%b v=1 r=0", k, qa, vout_a, rout_a, held);
      end
    end
    @(negedge clk);
    rin_a = 1;
    e = m_func(2'b00 ^ 2'b11, 2'b01 ^ 2'b01, 1'b1);
    #1;
    total++;
    if (rout_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_ready_high: got %b want 1", rout_a);
    end
    @(posedge clk);
    #1;
    total++;
    if (vout_a !== 1'b1 || comb_a(qa) !== e) begin
      bad++;
      $display("[TB] FAIL bp_release: got v=%b q=%b want v=1 q=%b", vout_a, comb_a(qa), e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      xa = 4'($urandom()); ya = 4'($urandom()); za = 2'($urandom()); mode_a = 1'($urandom());
      e = m_func(xa[1:0] ^ xa[3:2], ya[1:0] ^ ya[3:2], mode_a);
      #1;
      total++;
      if (rout_a !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_ready%0d: got %b want 1", k, rout_a);
      end
      @(posedge clk);
      #1;
      total++;
      if (vout_a !== 1'b1 || comb_a(qa) !== e) begin
        bad++;
        $display("[TB] FAIL b2b%0d: got v=%b q=%b want v=1 q=%b", k, vout_a, comb_a(qa), e);
      end
    end
    @(negedge clk);
    vin_a = 0;
    held = qa;
    @(posedge clk);
    #1;
    total++;
    if (vout_a !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain: got v=%b want 0", vout_a);
    end
    @(negedge clk);
    xa = ~xa; ya = ~ya; za = ~za; mode_a = ~mode_a;
    @(posedge clk);
    #1;
    total++;
    if (qa !== held) begin
      bad++;
      $display("[TB] FAIL idle_hold: got %b want %b", qa, held);
    end
  endtask

  task automatic test_regression;
    int accepted = 0;
    int cycles = 0;
    logic exp_valid = 1'b0;
    logic exp_rdy, acc;
    logic [7:0] exp_val = '0;
    logic [7:0] nv;
    while (accepted < 10000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      xb = 24'($urandom()); yb = 24'($urandom()); zb = 24'($urandom());
      mode_b = 1'($urandom());
      vin_b = ($urandom_range(3) != 0);
      rin_b = ($urandom_range(3) != 0);
      nv = exp_b(xb, yb, mode_b);
      #1;
      exp_rdy = !exp_valid | rin_b;
      acc = vin_b & exp_rdy;
      total++;
      if (rout_b !== exp_rdy) begin
        bad++;
        $display("[TB] FAIL regr_ready c=%0d: got %b want %b", cycles, rout_b, exp_rdy);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        exp_valid = 1'b1;
        exp_val = nv;
        accepted++;
      end else if (rin_b) begin
        exp_valid = 1'b0;
      end
      total++;
      if (vout_b !== exp_valid || (exp_valid && lanes_b(qb) !== exp_val)) begin
        bad++;
        $display("[TB] FAIL regr_data c=%0d: got v=%b q=%h want v=%b q=%h",
                 cycles, vout_b, lanes_b(qb), exp_valid, exp_val);
      end
    end
    total++;
    if (accepted < 10000) begin
      bad++;
      $display("[TB] FAIL regr_timeout: got %0d beats want 10000", accepted);
    end
  endtask

  task automatic test_midreset;
    logic [7:0] e;
    @(negedge clk);
    xb = 24'($urandom()); yb = 24'($urandom()); zb = 24'($urandom());
    mode_b = 1; vin_b = 1; rin_b = 1;
    @(posedge clk);
    #1;
    rin_b = 0;
    total++;
    if (vout_b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_pre: got v=%b want 1", vout_b);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (vout_b !== 1'b0 || qb !== 24'b0 || rout_b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset: got v=%b q=%h r=%b want v=0 q=0 r=1", vout_b, qb, rout_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xb = 24'($urandom()); yb = 24'($urandom()); zb = 24'($urandom());
    mode_b = 0; vin_b = 1; rin_b = 1;
    e = exp_b(xb, yb, mode_b);
    @(posedge clk);
    #1;
    vin_b = 0;
    total++;
    if (vout_b !== 1'b1 || lanes_b(qb) !== e) begin
      bad++;
      $display("[TB] FAIL mid_after: got v=%b q=%h want v=1 q=%h", vout_b, lanes_b(qb), e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_backpressure();
    test_regression();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dom_shared_gf4_mac_pipe.md
DOM_SHARED_GF4_MAC_PIPE -- requirements
Module: dom_shared_gf4_mac_pipe

Interface
REQ-001 Parameter SHARES, default 2, number of Boolean shares per operand, legal range 2..4.
REQ-002 Parameter LANES, default 1, number of independent GF(2^2) channels processed in parallel, legal range 1..8.
REQ-003 Parameter P (localparam), SHARES*(SHARES-1)/2, number of cross-domain share pairs per lane.
REQ-004 ClkxCI  in  1  single clock; all registers update on the rising edge.
REQ-005 RstxBI  in  1  asynchronous, active-low reset.
REQ-006 _XxDI  in  2*SHARES*LANES  shared operand X; bit b of share s in lane l at index (l*SHARES+s)*2+b.
REQ-007 _YxDI  in  2*SHARES*LANES  shared operand Y; same layout as _XxDI.
REQ-008 _ZxDI  in  2*P*LANES  fresh randomness; pair p of lane l at (l*P+p)*2+b; pairs enumerated (0,1),(0,2)..(1,2).. lexicographically, i<j.
REQ-009 ModexSI  in  1  0 = multiply, 1 = square-scale-multiply-accumulate.
REQ-010 ValidxSI  in  1  input beat valid.
REQ-011 ReadyxSO  out  1  block accepts the beat this cycle.
REQ-012 _QxDO  out  2*SHARES*LANES  shared result; same layout as _XxDI.
REQ-013 ValidxSO  out  1  _QxDO holds an unconsumed result.
REQ-014 ReadyxSI  in  1  downstream consumes the result this cycle.

Function
REQ-015 GF(2^2) normal-basis multiply mul(a,b): e=(a1^a0)&(b1^b0); result={ (a1&b1)^e, (a0&b0)^e }.
REQ-016 Square-scale sqsc(a) SHALL equal {a1, a1^a0}.
REQ-017 Unshared function per lane: Mode 0 -> Q=mul(X,Y); Mode 1 -> Q=sqsc(X^Y)^mul(X,Y).
REQ-018 Accept event SHALL be ValidxSI & ReadyxSO; inputs, Z and Mode SHALL be sampled only on accept.
REQ-019 On accept, per lane and share i, register inner term mul(X_i,Y_i), plus sqsc(X_i^Y_i) when Mode=1.
REQ-020 On accept, for every i!=j register cross term mul(X_i,Y_j)^Z_{min(i,j),max(i,j)}; Z shared by (i,j) and (j,i).
REQ-021 Q_i SHALL be XOR of share i's registered inner term and all its registered cross terms; no unregistered cross-domain path to _QxDO.
REQ-022 Latency SHALL be exactly 1 cycle: beat accepted at edge k gives ValidxSO=1 and valid _QxDO after edge k.
REQ-023 ReadyxSO SHALL equal !ValidxSO | ReadyxSI (combinational, one-deep output).
REQ-024 ValidxSO: set on accept; cleared on ReadyxSI without accept; held with _QxDO stable while ReadyxSI=0.
REQ-025 Simultaneous consume and accept SHALL keep ValidxSO=1 and replace the result with the new beat, no bubble.
REQ-026 Lanes SHALL be independent; no randomness or term shared across lanes.
REQ-027 ValidxSI deasserted SHALL leave all data registers unchanged (no glitch-propagating recomputation).

Reset
REQ-028 RstxBI=0 SHALL asynchronously clear ValidxSO and all term registers, so _QxDO=0 and ReadyxSO=1.
REQ-029 Reset mid-operation SHALL drop any held result; first beat after release is accepted normally.

Verification
REQ-030 SHARES=2,LANES=1, Mode0, X=10 (X0=10,X1=00), Y=01, Z random -> one cycle later XOR of Q shares=11, ValidxSO=1.
REQ-031 Same X,Y with Mode1 -> recombined Q=01; X=11,Y=11 Mode1 -> Q=11.
REQ-032 Exhaustive: all 256 share splittings of X,Y (SHARES=2) per mode, random Z each beat -> recombined Q equals REQ-017 model every beat.
REQ-033 Backpressure: ReadyxSI=0 for 3 cycles with ValidxSI=1 -> ReadyxSO=0, _QxDO stable, no beat lost; ReadyxSI=1 -> back-to-back throughput 1 beat/cycle.
REQ-034 SHARES=3,LANES=4 random regression 10^4 beats -> all lanes match model; assert RstxBI mid-stream -> ValidxSO=0, _QxDO=0 immediately.
